// File: rtl/mc_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : mc_controller_if
// Description : Bundle between the multicycle main controller and the MIPS32
//               datapath. It carries the opcode and zero flag into the
//               controller, and the datapath enables and selects back out.
//               master : controller side (drives enables/selects)
//               slave  : datapath side (drives op/zero)
// Revision    : 1.0 - initial release
// ============================================================================
interface mc_controller_if;
    logic [5:0] op;        // instr[31:26] from the instruction register
    logic       zero;      // ALU zero / branch-condition flag
    logic       pcen;      // PC register enable
    logic       memwrite;  // data memory write enable
    logic       irwrite;   // instruction register load
    logic       regwrite;  // register file write enable
    logic       alusrca;   // 0 = PC, 1 = register A
    logic [2:0] alusrcb;   // ALU B operand select
    logic       iord;      // 0 = PC, 1 = ALUOut as memory address
    logic       memtoreg;  // 1 = writeback from memory data register
    logic       regdst;    // 1 = rd, 0 = rt
    logic [1:0] pcsrc;     // 00 = ALU, 01 = ALUOut, 10 = jump target
    logic [2:0] aluop;     // to the ALU decoder
    logic       illegal;   // one-cycle pulse on unsupported opcode

    modport master (
        input  op, zero,
        output pcen, memwrite, irwrite, regwrite, alusrca, alusrcb,
               iord, memtoreg, regdst, pcsrc, aluop, illegal
    );

    modport slave (
        output op, zero,
        input  pcen, memwrite, irwrite, regwrite, alusrca, alusrcb,
               iord, memtoreg, regdst, pcsrc, aluop, illegal
    );
endinterface
`default_nettype wire

// File: rtl/mc_controller.sv
`default_nettype none
// ============================================================================
// Module      : mc_controller
// Description : Multicycle main controller (Moore FSM) for the MIPS32 core.
//               Sequences fetch/decode/execute/memory/writeback and drives
//               every datapath enable and select.
// Ports       : clk   - clock, rising edge
//               reset - synchronous, active-high; forces all enables low
//               bus   - mc_controller_if.master (op/zero in, controls out)
// Revision    : 1.0 - initial release
// ============================================================================
module mc_controller (
    input  logic            clk,
    input  logic            reset,
    mc_controller_if.master bus
);
    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BEQEX   = 4'd8,
        S_BLEZEX  = 4'd9,
        S_IEXEC   = 4'd10,
        S_IWB     = 4'd11,
        S_JEX     = 4'd12
    } state_t;

    localparam logic [5:0] C_OP_RTYPE = 6'b000000;
    localparam logic [5:0] C_OP_J     = 6'b000010;
    localparam logic [5:0] C_OP_BEQ   = 6'b000100;
    localparam logic [5:0] C_OP_BLEZ  = 6'b000110;
    localparam logic [5:0] C_OP_ADDI  = 6'b001000;
    localparam logic [5:0] C_OP_SLTI  = 6'b001010;
    localparam logic [5:0] C_OP_ORI   = 6'b001101;
    localparam logic [5:0] C_OP_XORI  = 6'b001110;
    localparam logic [5:0] C_OP_LUI   = 6'b001111;
    localparam logic [5:0] C_OP_LW    = 6'b100011;
    localparam logic [5:0] C_OP_SW    = 6'b101011;

    state_t     r_state;
    state_t     w_next;
    logic [5:0] r_op;      // opcode captured in DECODE, held for the instruction

    logic       w_pcwrite, w_branch, w_memwrite, w_irwrite, w_regwrite;
    logic       w_alusrca, w_iord, w_memtoreg, w_regdst, w_illegal;
    logic [2:0] w_alusrcb, w_aluop;
    logic [1:0] w_pcsrc;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
            r_op    <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE) begin
                r_op <= bus.op;
            end
        end
    end

    always_comb begin
        w_next     = S_FETCH;
        w_pcwrite  = 1'b0;
        w_branch   = 1'b0;
        w_memwrite = 1'b0;
        w_irwrite  = 1'b0;
        w_regwrite = 1'b0;
        w_alusrca  = 1'b0;
        w_alusrcb  = 3'b000;
        w_iord     = 1'b0;
        w_memtoreg = 1'b0;
        w_regdst   = 1'b0;
        w_pcsrc    = 2'b00;
        w_aluop    = 3'b000;
        w_illegal  = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_alusrcb = 3'b001;
                w_irwrite = 1'b1;
                w_pcwrite = 1'b1;
                w_next    = S_DECODE;
            end
            S_DECODE: begin
                // ALU precomputes PC + (imm << 2) for a possible branch.
                w_alusrcb = 3'b011;
                case (bus.op)
                    C_OP_LW, C_OP_SW: w_next = S_MEMADR;
                    C_OP_RTYPE:       w_next = S_EXECUTE;
                    C_OP_BEQ:         w_next = S_BEQEX;
                    C_OP_BLEZ:        w_next = S_BLEZEX;
                    C_OP_J:           w_next = S_JEX;
                    C_OP_ADDI, C_OP_SLTI, C_OP_ORI, C_OP_XORI, C_OP_LUI:
                                      w_next = S_IEXEC;
                    default: begin
                        w_illegal = 1'b1;
                        w_next    = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                w_alusrca = 1'b1;
                w_alusrcb = 3'b010;
                w_next    = (r_op == C_OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                w_iord = 1'b1;
                w_next = S_MEMWB;
            end
            S_MEMWB: begin
                w_memtoreg = 1'b1;
                w_regwrite = 1'b1;
            end
            S_MEMWR: begin
                w_iord     = 1'b1;
                w_memwrite = 1'b1;
            end
            S_EXECUTE: begin
                w_alusrca = 1'b1;
                w_aluop   = 3'b111;
                w_next    = S_ALUWB;
            end
            S_ALUWB: begin
                w_regdst   = 1'b1;
                w_regwrite = 1'b1;
            end
            S_BEQEX, S_BLEZEX: begin
                w_alusrca = 1'b1;
                w_pcsrc   = 2'b01;
                w_branch  = 1'b1;
                w_aluop   = (r_state == S_BEQEX) ? 3'b001 : 3'b010;
            end
            S_IEXEC: begin
                w_alusrca = 1'b1;
                w_next    = S_IWB;
                case (r_op)
                    C_OP_SLTI: begin w_aluop = 3'b110; w_alusrcb = 3'b010; end
                    C_OP_ORI:  begin w_aluop = 3'b011; w_alusrcb = 3'b100; end
                    C_OP_XORI: begin w_aluop = 3'b101; w_alusrcb = 3'b100; end
                    C_OP_LUI:  begin w_aluop = 3'b100; w_alusrcb = 3'b100; end
                    default:   begin w_aluop = 3'b000; w_alusrcb = 3'b010; end
                endcase
            end
            S_IWB: begin
                w_regwrite = 1'b1;
            end
            S_JEX: begin
                w_pcsrc   = 2'b10;
                w_pcwrite = 1'b1;
            end
            default: w_next = S_FETCH;
        endcase
    end

    // Reset gates every output combinationally so an instruction interrupted
    // by reset issues no write enable in the reset cycle itself.
    assign bus.pcen     = ~reset & (w_pcwrite | (w_branch & bus.zero));
    assign bus.memwrite = ~reset & w_memwrite;
    assign bus.irwrite  = ~reset & w_irwrite;
    assign bus.regwrite = ~reset & w_regwrite;
    assign bus.illegal  = ~reset & w_illegal;
    assign bus.alusrca  = ~reset & w_alusrca;
    assign bus.iord     = ~reset & w_iord;
    assign bus.memtoreg = ~reset & w_memtoreg;
    assign bus.regdst   = ~reset & w_regdst;
    assign bus.alusrcb  = reset ? 3'b000 : w_alusrcb;
    assign bus.pcsrc    = reset ? 2'b00  : w_pcsrc;
    assign bus.aluop    = reset ? 3'b000 : w_aluop;
endmodule
`default_nettype wire

// File: tb/tb_mc_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_mc_controller
// Description : Self-checking bench for mc_controller. Each cycle applies
//               {reset, op, zero} and the expected output word; expectations
//               queue up when driven and are compared on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mc_controller;
    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic        zero;
        logic [16:0] exp;
        string       name;
    } vec_t;

    typedef struct {
        logic [16:0] exp;
        string       name;
    } sb_t;

    logic clk;
    logic reset;
    mc_controller_if bus ();

    mc_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    vec_t tbl[$];
    sb_t  sb[$];
    int   n_vec;
    int   n_err;

    // {pcen,memwrite,irwrite,regwrite,alusrca,alusrcb[2:0],iord,memtoreg,
    //  regdst,pcsrc[1:0],aluop[2:0],illegal}
    function automatic logic [16:0] mk(input logic pcen, input logic mw,
            input logic irw, input logic rw, input logic asa,
            input logic [2:0] asb, input logic iord, input logic m2r,
            input logic rd, input logic [1:0] pcs, input logic [2:0] aop,
            input logic ill);
        return {pcen, mw, irw, rw, asa, asb, iord, m2r, rd, pcs, aop, ill};
    endfunction

    localparam logic [5:0] OP_R = 6'b000000, OP_J = 6'b000010,
        OP_BEQ = 6'b000100, OP_BLEZ = 6'b000110, OP_ADDI = 6'b001000,
        OP_SLTI = 6'b001010, OP_ORI = 6'b001101, OP_XORI = 6'b001110,
        OP_LUI = 6'b001111, OP_LW = 6'b100011, OP_SW = 6'b101011,
        OP_BAD = 6'b111111;

    logic [16:0] x_rst, x_fetch, x_dec, x_ill, x_madr, x_mrd, x_mwb, x_mwr;
    logic [16:0] x_exe, x_awb, x_iwb, x_jex;

    function automatic logic [16:0] x_br(input logic z, input logic [2:0] aop);
        return mk(z, 0, 0, 0, 1, 3'b000, 0, 0, 0, 2'b01, aop, 0);
    endfunction

    function automatic logic [16:0] x_iex(input logic [2:0] aop, input logic [2:0] asb);
        return mk(0, 0, 0, 0, 1, asb, 0, 0, 0, 2'b00, aop, 0);
    endfunction

    task automatic add(input logic rst, input logic [5:0] op, input logic z,
                       input logic [16:0] e, input string nm);
        vec_t v;
        v.rst = rst; v.op = op; v.zero = z; v.exp = e; v.name = nm;
        tbl.push_back(v);
    endtask

    task automatic apply(input logic rst, input logic [5:0] op, input logic z,
                         input logic [16:0] e, input string nm);
        sb_t s;
        @(posedge clk);
        #1;
        reset    = rst;
        bus.op   = op;
        bus.zero = z;
        s.exp  = e;
        s.name = nm;
        sb.push_back(s);
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            sb_t s;
            logic [16:0] act;
            s = sb.pop_front();
            act = {bus.pcen, bus.memwrite, bus.irwrite, bus.regwrite,
                   bus.alusrca, bus.alusrcb, bus.iord, bus.memtoreg,
                   bus.regdst, bus.pcsrc, bus.aluop, bus.illegal};
            n_vec++;
            if (act !== s.exp) begin
                n_err++;
                $display("FAIL %s: got %05h expected %05h", s.name, act, s.exp);
            end
        end
    end

    logic [5:0] it_op  [5];
    logic [2:0] it_aop [5];
    logic [2:0] it_asb [5];

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        bus.op = OP_R;
        bus.zero = 1'b0;

        x_rst   = '0;
        x_fetch = mk(1, 0, 1, 0, 0, 3'b001, 0, 0, 0, 2'b00, 3'b000, 0);
        x_dec   = mk(0, 0, 0, 0, 0, 3'b011, 0, 0, 0, 2'b00, 3'b000, 0);
        x_ill   = mk(0, 0, 0, 0, 0, 3'b011, 0, 0, 0, 2'b00, 3'b000, 1);
        x_madr  = mk(0, 0, 0, 0, 1, 3'b010, 0, 0, 0, 2'b00, 3'b000, 0);
        x_mrd   = mk(0, 0, 0, 0, 0, 3'b000, 1, 0, 0, 2'b00, 3'b000, 0);
        x_mwb   = mk(0, 0, 0, 1, 0, 3'b000, 0, 1, 0, 2'b00, 3'b000, 0);
        x_mwr   = mk(0, 1, 0, 0, 0, 3'b000, 1, 0, 0, 2'b00, 3'b000, 0);
        x_exe   = mk(0, 0, 0, 0, 1, 3'b000, 0, 0, 0, 2'b00, 3'b111, 0);
        x_awb   = mk(0, 0, 0, 1, 0, 3'b000, 0, 0, 1, 2'b00, 3'b000, 0);
        x_iwb   = mk(0, 0, 0, 1, 0, 3'b000, 0, 0, 0, 2'b00, 3'b000, 0);
        x_jex   = mk(1, 0, 0, 0, 0, 3'b000, 0, 0, 0, 2'b10, 3'b000, 0);

        // Reset, then lw; op changes after DECODE must be ignored.
        add(1, OP_LW, 1, x_rst,   "reset0");
        add(1, OP_LW, 1, x_rst,   "reset1");
        add(0, OP_LW, 0, x_fetch, "lw_fetch");
        add(0, OP_LW, 0, x_dec,   "lw_decode");
        add(0, OP_SW, 1, x_madr,  "lw_memadr");
        add(0, OP_R,  1, x_mrd,   "lw_memrd");
        add(0, OP_R,  0, x_mwb,   "lw_memwb");
        // R-type
        add(0, OP_R,  0, x_fetch, "r_fetch");
        add(0, OP_R,  0, x_dec,   "r_decode");
        add(0, OP_LW, 0, x_exe,   "r_execute");
        add(0, OP_LW, 0, x_awb,   "r_aluwb");
        // beq taken / not taken
        add(0, OP_BEQ, 1, x_fetch,           "beq1_fetch");
        add(0, OP_BEQ, 1, x_dec,             "beq1_decode");
        add(0, OP_R,   1, x_br(1, 3'b001),   "beq_taken");
        add(0, OP_BEQ, 0, x_fetch,           "beq0_fetch");
        add(0, OP_BEQ, 0, x_dec,             "beq0_decode");
        add(0, OP_R,   0, x_br(0, 3'b001),   "beq_not_taken");
        // blez taken / not taken
        add(0, OP_BLEZ, 0, x_fetch,          "blez1_fetch");
        add(0, OP_BLEZ, 0, x_dec,            "blez1_decode");
        add(0, OP_BLEZ, 1, x_br(1, 3'b010),  "blez_taken");
        add(0, OP_BLEZ, 0, x_fetch,          "blez0_fetch");
        add(0, OP_BLEZ, 0, x_dec,            "blez0_decode");
        add(0, OP_BLEZ, 0, x_br(0, 3'b010),  "blez_not_taken");
        // I-type sweep; op is scrambled in IEXEC and zero is high there.
        it_op  = '{OP_ORI, OP_LUI, OP_XORI, OP_SLTI, OP_ADDI};
        it_aop = '{3'b011, 3'b100, 3'b101, 3'b110, 3'b000};
        it_asb = '{3'b100, 3'b100, 3'b100, 3'b010, 3'b010};
        for (int i = 0; i < 5; i++) begin
            add(0, it_op[i], 0, x_fetch, "i_fetch");
            add(0, it_op[i], 0, x_dec,   "i_decode");
            add(0, OP_R,     1, x_iex(it_aop[i], it_asb[i]), "i_iexec");
            add(0, OP_BEQ,   1, x_iwb,   "i_iwb");
        end
        // Illegal opcode: one-cycle pulse, straight back to FETCH.
        add(0, OP_BAD, 0, x_fetch, "ill_fetch");
        add(0, OP_BAD, 0, x_ill,   "ill_decode");
        add(0, OP_J,   0, x_fetch, "ill_refetch");
        // Jump
        add(0, OP_J,   0, x_dec,   "j_decode");
        add(0, OP_J,   0, x_jex,   "j_jex");
        // sw interrupted by reset in MEMWR
        add(0, OP_SW,  0, x_fetch, "sw_fetch");
        add(0, OP_SW,  0, x_dec,   "sw_decode");
        add(0, OP_SW,  0, x_madr,  "sw_memadr");
        add(1, OP_SW,  1, x_rst,   "sw_reset_memwr");
        add(0, OP_SW,  0, x_fetch, "sw_after_reset");
        add(0, OP_SW,  0, x_dec,   "sw2_decode");
        add(0, OP_SW,  0, x_madr,  "sw2_memadr");
        add(0, OP_LW,  0, x_mwr,   "sw2_memwr");

        foreach (tbl[i]) begin
            apply(tbl[i].rst, tbl[i].op, tbl[i].zero, tbl[i].exp, tbl[i].name);
        end

        // Hand sequence: reset lands in MEMRD of a lw, then a jump follows.
        apply(0, OP_LW, 0, x_fetch, "h_lw_fetch");
        apply(0, OP_LW, 0, x_dec,   "h_lw_decode");
        apply(0, OP_LW, 0, x_madr,  "h_lw_memadr");
        apply(1, OP_LW, 0, x_rst,   "h_reset_memrd");
        apply(0, OP_J,  0, x_fetch, "h_fetch_after_reset");
        apply(0, OP_J,  0, x_dec,   "h_j_decode");
        apply(0, OP_J,  0, x_jex,   "h_j_jex");
        apply(0, OP_J,  0, x_fetch, "h_j_refetch");

        @(posedge clk);
        @(negedge clk);
        #1;
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/mc_controller.md
# mc_controller

Multicycle main controller for the MIPS32 core: a Moore state machine that sequences each instruction through fetch, decode, execute, memory and writeback steps and drives all datapath enables. It sits directly upstream of the ALU decoder, supplying the 3-bit `aluop` that the decoder turns into a 4-bit ALU control. It also consumes the ALU `zero` flag to form the PC enable.

## Interface
- No parameters.
- `clk` input 1: single clock; all state changes on its rising edge.
- `reset` input 1: synchronous, active-high.
- `op` input 6: instruction opcode, `instr[31:26]` from the instruction register.
- `zero` input 1: ALU zero/condition flag. 1 means the branch condition is true for the current `aluop`.
- `pcen` output 1: PC register enable, `pcwrite | (branch & zero)`.
- `memwrite` output 1: data memory write enable.
- `irwrite` output 1: instruction register load.
- `regwrite` output 1: register file write enable.
- `alusrca` output 1: 0 = PC, 1 = register A.
- `alusrcb` output 3: ALU B operand select.
  - 000 = register B
  - 001 = constant 4
  - 010 = sign-extended immediate
  - 011 = sign-extended immediate << 2
  - 100 = zero-extended immediate
- `iord` output 1: memory address select; 0 = PC, 1 = ALUOut.
- `memtoreg` output 1: writeback select; 1 = memory data register.
- `regdst` output 1: 1 = rd, 0 = rt.
- `pcsrc` output 2: next-PC select; 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `aluop` output 3: to the ALU decoder.
  - 000 = add
  - 001 = sub
  - 010 = blez
  - 011 = ori
  - 100 = lui
  - 101 = xori
  - 110 = slti
  - 111 = R-type (use funct)
- `illegal` output 1: one-cycle pulse on an unsupported opcode.

## Operation
Opcodes and their next state after DECODE:
- lw 100011, sw 101011 -> MEMADR
- R-type 000000 -> EXECUTE
- beq 000100 -> BEQEX
- blez 000110 -> BLEZEX
- j 000010 -> JEX
- addi 001000, slti 001010, ori 001101, xori 001110, lui 001111 -> IEXEC

States, their asserted outputs, and transitions. Any output not listed is 0; `aluop` defaults to 000 and `alusrcb` to 000.
- FETCH: `iord`=0, `alusrca`=0, `alusrcb`=001, `aluop`=000, `pcsrc`=00, `irwrite`=1, `pcwrite`=1. Next: DECODE.
- DECODE: `alusrca`=0, `alusrcb`=011, `aluop`=000 (precomputes the branch target). Next: by opcode as above. Unknown opcode: `illegal`=1, next FETCH.
- MEMADR: `alusrca`=1, `alusrcb`=010, `aluop`=000. Next: MEMRD for lw, MEMWR for sw.
- MEMRD: `iord`=1. Next: MEMWB.
- MEMWB: `regdst`=0, `memtoreg`=1, `regwrite`=1. Next: FETCH.
- MEMWR: `iord`=1, `memwrite`=1. Next: FETCH.
- EXECUTE: `alusrca`=1, `alusrcb`=000, `aluop`=111. Next: ALUWB.
- ALUWB: `regdst`=1, `memtoreg`=0, `regwrite`=1. Next: FETCH.
- BEQEX: `alusrca`=1, `alusrcb`=000, `aluop`=001, `pcsrc`=01, `branch`=1. Next: FETCH.
- BLEZEX: as BEQEX but `aluop`=010. Next: FETCH.
- IEXEC: `alusrca`=1. `aluop` and `alusrcb` come from the opcode latched in DECODE:
  - addi: `aluop`=000, `alusrcb`=010
  - slti: `aluop`=110, `alusrcb`=010
  - ori: `aluop`=011, `alusrcb`=100
  - xori: `aluop`=101, `alusrcb`=100
  - lui: `aluop`=100, `alusrcb`=100
  - Next: IWB.
- IWB: `regdst`=0, `memtoreg`=0, `regwrite`=1. Next: FETCH.
- JEX: `pcsrc`=10, `pcwrite`=1. Next: FETCH.

Opcode handling:
- `op` is registered internally at the DECODE cycle and held for the rest of the instruction.
- Later states never re-sample `op`, so a change on `op` after DECODE has no effect.

## Timing
- Moore outputs: all outputs are a function of registered state only. The exception is `pcen`, which is combinational from `zero` in BEQEX and BLEZEX.
- Cycles per instruction, FETCH through the return to FETCH:
  - lw: 5
  - sw, R-type, I-type: 4
  - beq, blez, j: 3
  - illegal: 2
- Reset:
  - While `reset`=1, every enable output is forced to 0: `pcen`, `memwrite`, `irwrite`, `regwrite`, `illegal`.
  - `aluop`=000, `alusrcb`=000, `pcsrc`=00, all other selects 0.
  - The state register loads FETCH on the clock edge where `reset`=1.
  - The first FETCH outputs appear in the first cycle after `reset` falls.
- Reset mid-instruction aborts the instruction with no further write enables; the next cycle after release is FETCH.
- Branch semantics: `zero` is sampled only in BEQEX and BLEZEX. `pcen` = `zero` in those states; `zero` is ignored elsewhere.
- `illegal` is exactly one cycle wide, and only in DECODE.

## Test plan
- Reset then release, with `op`=100011 (lw): states FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH. `regwrite`=1 and `memtoreg`=1 only in cycle 5. `pcen`=1 only in cycles 1 and 6.
- `op`=000000 (R-type): cycle 3 has `aluop`=111 and `alusrcb`=000. Cycle 4 has `regwrite`=1 and `regdst`=1. Back in FETCH at cycle 5.
- beq with `zero`=1 in cycle 3: `pcen`=1, `pcsrc`=01, `aluop`=001. Repeat with `zero`=0: `pcen`=0. blez: same checks with `aluop`=010.
- I-type sweep, checking cycle 3 (`aluop`, `alusrcb`) and `regwrite`=1 in cycle 4:
  - ori -> (011, 100)
  - lui -> (100, 100)
  - xori -> (101, 100)
  - slti -> (110, 010)
  - addi -> (000, 010)
- `op`=111111: `illegal`=1 for one cycle in DECODE, no write enables, FETCH in cycle 3. j: `pcsrc`=10 and `pcen`=1 in cycle 3.
- Assert `reset` during MEMWR of sw: `memwrite`=0 in that cycle. FETCH in the first cycle after release, with no stray `regwrite` or `memwrite`.
